alu_cmd_sequencer: RTL and testbench

//  Upstream issue/capture stage for the combinational 4-bit ALU (alu_top).

---
 rtl/alu_cmd_sequencer_pkg.sv | 25 ++
 rtl/alu_cmd_sequencer_if.sv | 32 +++
 rtl/alu_cmd_sequencer.sv | 106 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcode encodings and sequencer FSM states for the 4-bit ALU slice.
// Imported by the sequencer, the ALU and the bench.
package alu_cmd_sequencer_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_AVG  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Division by zero is the only case where the sequencer overrides the ALU.
    function automatic logic is_div0(input logic [2:0] opcode, input logic [3:0] b);
        return (opcode == OP_DIV) && (b == 4'd0);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready channels between a requester (master)
// and the ALU command sequencer (slave).
interface alu_cmd_sequencer_if #(
    parameter int TAG_W = 4
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_a;
    logic [3:0]       cmd_b;
    logic [2:0]       cmd_opcode;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_tag
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue/capture stage for the combinational 4-bit ALU: registers a command onto
// the ALU inputs, captures the settled result one cycle later, returns it.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int         TAG_W       = 4,
    parameter int         CNT_W       = 8,
    parameter logic [7:0] DIV0_RESULT = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    output logic [CNT_W-1:0]  op_count
);

    state_t           state;
    state_t           state_next;
    logic [TAG_W-1:0] tag_q;
    logic             cmd_fire;
    logic             rsp_fire;
    logic             div0;
    logic [7:0]       capt_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In RESP a new command may be taken in the same cycle the response leaves.
    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                bus.cmd_ready = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    state_next = bus.cmd_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (rst) begin
            bus.cmd_ready = 1'b0;
        end
    end

    assign bus.rsp_valid = (state == ST_RESP);
    assign cmd_fire      = bus.cmd_valid & bus.cmd_ready;
    assign rsp_fire      = bus.rsp_valid & bus.rsp_ready;
    assign div0          = is_div0(alu_opcode, alu_b);
    assign capt_result   = div0 ? DIV0_RESULT : alu_result;

    // The alu_* registers only change on acceptance so the ALU sees stable
    // operands through EXEC and while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a          <= 4'd0;
            alu_b          <= 4'd0;
            alu_opcode     <= 3'd0;
            tag_q          <= '0;
            bus.rsp_result <= 8'h00;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_err    <= 1'b0;
            bus.rsp_tag    <= '0;
            op_count       <= '0;
        end else begin
            if (cmd_fire) begin
                alu_a      <= bus.cmd_a;
                alu_b      <= bus.cmd_b;
                alu_opcode <= bus.cmd_opcode;
                tag_q      <= bus.cmd_tag;
            end
            if (state == ST_EXEC) begin
                bus.rsp_result <= capt_result;
                bus.rsp_carry  <= div0 ? 1'b0 : alu_carry;
                bus.rsp_zero   <= (capt_result == 8'h00);
                bus.rsp_err    <= div0;
                bus.rsp_tag    <= tag_q;
            end
            if (rsp_fire) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed spec scenarios followed by
// randomized traffic scored against a transaction-level queue model.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int         TAG_W       = 4;
    localparam int         CNT_W       = 2;
    localparam logic [7:0] DIV0_RESULT = 8'hA5;

    typedef struct {
        logic [7:0]       result;
        logic             carry;
        logic             zero;
        logic             err;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_opcode;
    logic [7:0]       alu_result;
    logic             alu_carry;
    logic [CNT_W-1:0] op_count;

    int   checks = 0;
    int   errors = 0;
    int   model_count = 0;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.TAG_W(TAG_W)) bus ();

    alu_cmd_sequencer #(
        .TAG_W(TAG_W),
        .CNT_W(CNT_W),
        .DIV0_RESULT(DIV0_RESULT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .alu_carry(alu_carry),
        .op_count(op_count)
    );

    // Stand-in for alu_top; divide-by-zero deliberately returns junk with carry set.
    function automatic logic [8:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        int   ia;
        int   ib;
        int   r;
        logic c;
        ia = int'(a);
        ib = int'(b);
        r  = 0;
        c  = 1'b0;
        case (op)
            OP_ADD:  begin r = (ia + ib) % 16; c = (ia + ib) > 15; end
            OP_SUB:  begin r = (ia - ib + 16) % 16; c = ia < ib; end
            OP_MUL:  r = ia * ib;
            OP_DIV:  if (ib == 0) begin r = 255; c = 1'b1; end else r = ia / ib;
            OP_NAND: r = 15 - (ia & ib);
            OP_NOT:  r = 15 - ia;
            OP_CMP:  r = (ia < ib) ? 1 : ((ia == ib) ? 2 : 4);
            default: r = (ia + ib) / 2;
        endcase
        return {c, 8'(r)};
    endfunction

    assign {alu_carry, alu_result} = alu_model(alu_a, alu_b, alu_opcode);

    function automatic rsp_t expect_rsp(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op, input logic [TAG_W-1:0] tag);
        rsp_t       r;
        logic [8:0] m;
        m = alu_model(a, b, op);
        if (op == OP_DIV && b == 4'd0) begin
            r.result = DIV0_RESULT;
            r.carry  = 1'b0;
            r.err    = 1'b1;
        end else begin
            r.result = m[7:0];
            r.carry  = m[8];
            r.err    = 1'b0;
        end
        r.zero = (r.result == 8'h00);
        r.tag  = tag;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                                  input logic [TAG_W-1:0] tag, input logic vld, input logic rdy);
        bus.cmd_valid  = vld;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_opcode = op;
        bus.cmd_tag    = tag;
        bus.rsp_ready  = rdy;
        #1;
    endtask

    // One full transaction from IDLE, checking each phase against spec constants.
    task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input logic [TAG_W-1:0] tag,
                          input logic [7:0] e_res, input logic e_carry, input logic e_zero,
                          input logic e_err);
        apply_stimulus(a, b, op, tag, 1'b1, 1'b0);
        check_output({name, ".cmd_ready"}, 32'(bus.cmd_ready), 1);
        @(negedge clk);
        apply_stimulus(~a, ~b, ~op, ~tag, 1'b0, 1'b0);
        check_output({name, ".exec_valid"}, 32'(bus.rsp_valid), 0);
        check_output({name, ".alu_a"}, 32'(alu_a), 32'(a));
        check_output({name, ".alu_b"}, 32'(alu_b), 32'(b));
        check_output({name, ".alu_opcode"}, 32'(alu_opcode), 32'(op));
        @(negedge clk);
        check_output({name, ".rsp_valid"}, 32'(bus.rsp_valid), 1);
        check_output({name, ".result"}, 32'(bus.rsp_result), 32'(e_res));
        check_output({name, ".carry"}, 32'(bus.rsp_carry), 32'(e_carry));
        check_output({name, ".zero"}, 32'(bus.rsp_zero), 32'(e_zero));
        check_output({name, ".err"}, 32'(bus.rsp_err), 32'(e_err));
        check_output({name, ".tag"}, 32'(bus.rsp_tag), 32'(tag));
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        model_count++;
        #1;
        check_output({name, ".op_count"}, 32'(op_count), 32'(model_count % 4));
        check_output({name, ".idle_valid"}, 32'(bus.rsp_valid), 0);
        check_output({name, ".idle_ready"}, 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        rst_and_init();
    end

    task automatic rst_and_init();
        rsp_t r;
        logic pending;
        logic aged;
        logic exp_valid;
        logic exp_ready;

        rst = 1'b1;
        apply_stimulus(4'd0, 4'd0, 3'd0, '0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_output("reset.cmd_ready", 32'(bus.cmd_ready), 0);
        check_output("reset.rsp_valid", 32'(bus.rsp_valid), 0);
        check_output("reset.alu_a", 32'(alu_a), 0);
        check_output("reset.alu_opcode", 32'(alu_opcode), 0);
        check_output("reset.rsp_result", 32'(bus.rsp_result), 0);
        check_output("reset.op_count", 32'(op_count), 0);
        rst = 1'b0;
        #1;
        check_output("reset.ready_after", 32'(bus.cmd_ready), 1);

        // First five completions after reset also walk op_count 1,2,3,0,1.
        run_op("add", 4'd9, 4'd8, OP_ADD, 4'd1, 8'h01, 1'b1, 1'b0, 1'b0);
        run_op("mul", 4'd15, 4'd15, OP_MUL, 4'd2, 8'hE1, 1'b0, 1'b0, 1'b0);
        run_op("sub", 4'd3, 4'd3, OP_SUB, 4'd3, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op("div0", 4'd7, 4'd0, OP_DIV, 4'd4, DIV0_RESULT, 1'b0, 1'b0, 1'b1);
        run_op("div", 4'd9, 4'd2, OP_DIV, 4'd5, 8'h04, 1'b0, 1'b0, 1'b0);

        // Backpressure then back-to-back: tag 3 held, tag 4 waits and is taken on release.
        apply_stimulus(4'd5, 4'd6, OP_ADD, 4'd3, 1'b1, 1'b0);
        @(negedge clk);
        apply_stimulus(4'd2, 4'd3, OP_MUL, 4'd4, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_output("bp.rsp_valid", 32'(bus.rsp_valid), 1);
            check_output("bp.result", 32'(bus.rsp_result), 32'h0B);
            check_output("bp.tag", 32'(bus.rsp_tag), 3);
            check_output("bp.cmd_ready", 32'(bus.cmd_ready), 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check_output("b2b.cmd_ready", 32'(bus.cmd_ready), 1);
        check_output("b2b.first_tag", 32'(bus.rsp_tag), 3);
        @(negedge clk);
        model_count++;
        apply_stimulus(4'd0, 4'd0, OP_ADD, 4'd0, 1'b0, 1'b0);
        check_output("b2b.exec_valid", 32'(bus.rsp_valid), 0);
        check_output("b2b.alu_a", 32'(alu_a), 2);
        check_output("b2b.op_count", 32'(op_count), 32'(model_count % 4));
        @(negedge clk);
        check_output("b2b.second_valid", 32'(bus.rsp_valid), 1);
        check_output("b2b.second_result", 32'(bus.rsp_result), 32'h06);
        check_output("b2b.second_tag", 32'(bus.rsp_tag), 4);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        model_count++;

        // Reset while the command sits in EXEC drops it entirely.
        apply_stimulus(4'd4, 4'd4, OP_ADD, 4'd7, 1'b1, 1'b0);
        @(negedge clk);
        apply_stimulus(4'd0, 4'd0, OP_ADD, 4'd0, 1'b0, 1'b0);
        check_output("rst_exec.in_exec", 32'(bus.rsp_valid), 0);
        rst = 1'b1;
        #1;
        check_output("rst_exec.ready_in_rst", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        model_count = 0;
        #1;
        check_output("rst_exec.rsp_valid", 32'(bus.rsp_valid), 0);
        check_output("rst_exec.op_count", 32'(op_count), 0);
        check_output("rst_exec.cmd_ready", 32'(bus.cmd_ready), 1);
        check_output("rst_exec.alu_a", 32'(alu_a), 0);
        check_output("rst_exec.rsp_tag", 32'(bus.rsp_tag), 0);
        repeat (2) begin
            @(negedge clk);
            check_output("rst_exec.no_rsp", 32'(bus.rsp_valid), 0);
        end

        // Randomized traffic scored against an in-order queue of expected responses.
        aged = 1'b1;
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            pending   = exp_q.size() != 0;
            exp_valid = pending && aged;
            exp_ready = !pending || (exp_valid && bus.rsp_ready);
            check_output("rand.rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
            check_output("rand.cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
            check_output("rand.op_count", 32'(op_count), 32'(model_count % 4));
            if (exp_valid && bus.rsp_ready) begin
                r = exp_q.pop_front();
                check_output("rand.result", 32'(bus.rsp_result), 32'(r.result));
                check_output("rand.carry", 32'(bus.rsp_carry), 32'(r.carry));
                check_output("rand.zero", 32'(bus.rsp_zero), 32'(r.zero));
                check_output("rand.err", 32'(bus.rsp_err), 32'(r.err));
                check_output("rand.tag", 32'(bus.rsp_tag), 32'(r.tag));
                model_count++;
            end
            if (bus.cmd_valid && exp_ready) begin
                exp_q.push_back(expect_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_opcode, bus.cmd_tag));
                aged = 1'b0;
            end else begin
                aged = 1'b1;
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

endmodule
